data_memory_param: RTL and testbench
====================================

// Module: data_memory_param
// PURPOSE
//  Parametrised data memory for the single-cycle/multi-cycle CPU datapath. Next generation of the word-only data RAM.
//  Adds byte/half/word access with sign or zero extension, a registered read with valid strobe, alignment and range
//  error reporting, and a sequential init FSM that loads the power-on pattern one word per cycle after reset.
//  Sits between the ALU address output and the write-back mux.
// PARAMETERS
//  DATA_W    32   word width in bits; multiple of 8, ≥16
//  DEPTH     128  number of words; power of two, ≥16
//  INIT_MODE 1    0: all words zero after init; 1: mem[i] = i (truncated to DATA_W)
// PORTS
//  clock_in     in   1       system clock; all state updates on posedge
//  reset        in   1       synchronous, active-high; sampled on posedge clock_in
//  address      in   32      byte address; word index = address[log2(DEPTH)+1:2]
//  writeData    in   DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
//  memWrite     in   1       store request this cycle
//  memRead      in   1       load request this cycle
//  size         in   2       00 byte, 01 half, 10 word, 11 reserved (→ err)
//  load_unsigned in  1       1: zero-extend byte/half loads; 0: sign-extend
//  readData     out  DATA_W  registered load result, right-aligned and extended
//  rd_valid     out  1       1-cycle pulse: readData holds the result of the previous cycle's load
//  busy         out  1       high while the init FSM runs; requests are ignored
//  err          out  1       1-cycle pulse, registered: previous request rejected
// BEHAVIOUR
//  - Reset (reset=1 at posedge): state←INIT, init_ptr←0, readData←0, rd_valid←0, err←0, busy←1 from next cycle.
//    Reset asserted mid-init or mid-operation restarts INIT from word 0. Memory contents are not cleared by reset
//    itself; the init FSM overwrites them.
//  - FSM: INIT writes mem[init_ptr] per INIT_MODE, init_ptr++ each cycle; after writing DEPTH-1 → IDLE.
//    Init takes exactly DEPTH cycles after reset deasserts; busy=1 throughout; busy=0 in IDLE.
//  - In INIT, memRead and memWrite are ignored: no write, rd_valid=0, err=0.
//  - IDLE store (memWrite=1, memRead=0, valid request): bytes written at posedge, using byte enables derived from
//    size and address[1:0] (little-endian lane 0 = [7:0]). Unselected bytes are unchanged.
//  - IDLE load (memRead=1, memWrite=0, valid request): word read combinationally, lane-selected, extended, and
//    registered; readData/rd_valid update at the next posedge (latency 1). rd_valid=0 on cycles without a load;
//    readData holds its last value.
//  - Rejected request → no memory change, rd_valid=0, err=1 next cycle. Rejected when:
//    misaligned (half with address[0]=1; word with address[1:0]≠0); size=11; address[31:log2(DEPTH)+2]≠0
//    (out of range); memRead and memWrite both high.
//  - Back-to-back load of an address stored in the previous cycle returns the new data (write completed at the
//    earlier posedge).
//  - Only one request per cycle exists; no read/write collision inside a cycle beyond the rejected case above.
//  - Store data wider than size is ignored beyond the selected lanes.
//  - For DATA_W>32, the byte lane logic generalises: address[log2(DATA_W/8)-1:0] selects the lane and the word
//    index shifts accordingly.
// STRUCTURE
//  - Package dmem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encoding (ST_INIT, ST_IDLE), and the
//    function computing init values.
//  - Sub-module dmem_lane_align (combinational): given size, address low bits, and load_unsigned, produces store
//    byte enables plus lane-shifted write data, and extracts/extends load data. Instantiated once.
//  - Top holds the memory array, init FSM and pointer, request validation, and the output registers.
// TESTING
//  1. Reset 1 cycle, then idle: busy=1 for 128 cycles then 0. Load word at 0x14 → readData=0x00000005, rd_valid
//     pulse 1 cycle later.
//  2. Store word 0xDEADBEEF at 0x20, then load bytes 0x20..0x23 signed → 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD,
//     0xFFFFFFDE. Unsigned at 0x23 → 0x000000DE.
//  3. Store half 0x8001 at 0x42, load word 0x40 → 0x80010010. Load half 0x42 signed → 0xFFFF8001.
//  4. Load word at 0x02, store half at 0x01, load with size=11, load address 0x200, memRead=memWrite=1 →
//     err pulse each time, rd_valid=0, memory unchanged.
//  5. Assert reset at init cycle 60: busy stays 1, init restarts. Word 0x3C reads 0x0F after busy falls
//     (128 cycles after reset release).
//  6. Requests issued while busy=1 → no write (verified later), err=0, rd_valid=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory: access sizes, init FSM states and
// the power-on content pattern.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    // Mode 1 seeds each word with its own index; any other mode clears it.
    function automatic logic [31:0] init_word(input int mode, input logic [31:0] idx);
        return (mode == 1) ? idx : 32'd0;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the CPU's right-aligned data and the memory word:
// store byte enables / shifted data, and load extraction with sign/zero extend.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LB     = $clog2(DATA_W / 8)
) (
    input  logic [1:0]          i_size,
    input  logic [LB-1:0]       i_lo,
    input  logic                i_unsigned,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W-1:0]   i_rword,
    output logic [DATA_W/8-1:0] o_be,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W-1:0]   o_rdata
);

    localparam int NB = DATA_W / 8;

    logic [LB+2:0]     w_shamt;
    logic [DATA_W-1:0] w_rsh;
    logic              w_sgn8;
    logic              w_sgn16;

    assign w_shamt = {i_lo, 3'b000};
    assign o_wdata = i_wdata << w_shamt;
    assign w_rsh   = i_rword >> w_shamt;
    assign w_sgn8  = ~i_unsigned & w_rsh[7];
    assign w_sgn16 = ~i_unsigned & w_rsh[15];

    // Reserved size yields no enables; the top rejects it anyway.
    always_comb begin
        o_be    = '0;
        o_rdata = w_rsh;
        case (size_e'(i_size))
            SZ_BYTE: begin
                o_be    = NB'(1) << i_lo;
                o_rdata = {{(DATA_W-8){w_sgn8}}, w_rsh[7:0]};
            end
            SZ_HALF: begin
                o_be    = NB'(3) << i_lo;
                o_rdata = {{(DATA_W-16){w_sgn16}}, w_rsh[15:0]};
            end
            SZ_WORD: begin
                o_be    = '1;
                o_rdata = w_rsh;
            end
            default: begin
                o_be    = '0;
                o_rdata = w_rsh;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_param.sv
// Parametrised data RAM with byte/half/word access, registered loads,
// request validation and a sequential power-on init FSM.
module data_memory_param
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 128,
    parameter int INIT_MODE = 1
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              memWrite,
    input  logic              memRead,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    output logic [DATA_W-1:0] readData,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);
    localparam int HI = AW + LB;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_e            r_state;
    logic [AW-1:0]     r_init_ptr;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rd_valid;
    logic              r_err;

    logic [AW-1:0]     w_idx;
    logic [LB-1:0]     w_lo;
    logic              w_oor;
    logic              w_misalign;
    logic              w_req;
    logic              w_ok;
    logic              w_idle;
    logic              w_st;
    logic              w_ld;
    logic              w_rej;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [DATA_W-1:0] w_rdata_ext;
    logic [DATA_W-1:0] w_rword;

    assign w_idx      = address[HI-1:LB];
    assign w_lo       = address[LB-1:0];
    assign w_oor      = |address[31:HI];
    assign w_misalign = ((size == SZ_HALF) && address[0]) ||
                        ((size == SZ_WORD) && (|w_lo));
    assign w_req      = memRead | memWrite;
    assign w_ok       = (memRead ^ memWrite) && !w_oor && !w_misalign && (size != SZ_RSVD);
    assign w_idle     = (r_state == ST_IDLE);
    assign w_st       = w_idle & w_ok & memWrite;
    assign w_ld       = w_idle & w_ok & memRead;
    assign w_rej      = w_idle & w_req & ~w_ok;
    assign w_rword    = r_mem[w_idx];

    dmem_lane_align #(
        .DATA_W (DATA_W),
        .LB     (LB)
    ) u_align (
        .i_size     (size),
        .i_lo       (w_lo),
        .i_unsigned (load_unsigned),
        .i_wdata    (writeData),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata_ext)
    );

    // Contents survive reset; the init sequence is what rewrites them.
    always_ff @(posedge clock_in) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                r_mem[r_init_ptr] <= DATA_W'(init_word(INIT_MODE, 32'(r_init_ptr)));
            end else if (w_st) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
            r_busy     <= 1'b1;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_ld;
            r_err      <= w_rej;
            if (w_ld) r_rdata <= w_rdata_ext;
            case (r_state)
                ST_INIT: begin
                    r_init_ptr <= r_init_ptr + 1'b1;
                    if (r_init_ptr == AW'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign readData = r_rdata;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_data_memory_param.sv
// Self-checking bench: byte-addressed reference model, directed scenarios and
// randomized request streams against data_memory_param (32-bit x 128).
module tb_data_memory_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mw = 1'b0;
    logic        mr = 1'b0;
    logic [1:0]  sz = '0;
    logic        uns = 1'b0;
    logic [31:0] rdata;
    logic        rv;
    logic        busy;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mb [512];
    logic [31:0] exp_rd;
    bit          exp_v;
    bit          exp_e;

    data_memory_param #(.DATA_W(32), .DEPTH(128), .INIT_MODE(1)) dut (
        .clock_in      (clk),
        .reset         (rst),
        .address       (addr),
        .writeData     (wdata),
        .memWrite      (mw),
        .memRead       (mr),
        .size          (sz),
        .load_unsigned (uns),
        .readData      (rdata),
        .rd_valid      (rv),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s, input bit u);
        mr = rd; mw = wr; addr = a; wdata = d; sz = s; uns = u;
        @(posedge clk);
        #1;
        mr = 1'b0; mw = 1'b0;
    endtask

    function automatic void model_init();
        for (int i = 0; i < 512; i++) mb[i] = 8'h00;
        for (int i = 0; i < 128; i++) mb[4*i] = 8'(i);
        exp_rd = '0;
    endfunction

    // Byte-addressed memory model: validity from the access rules, data by bytes.
    function automatic void model_req(input bit rd, input bit wr, input logic [31:0] a,
                                      input logic [31:0] d, input logic [1:0] s, input bit u);
        int          nb;
        bit          ok;
        logic [31:0] v;
        nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        ok = (rd != wr) && (s != 2'd3) && (a < 512) && ((a % nb) == 0);
        exp_e = (rd || wr) && !ok;
        exp_v = ok && rd;
        if (ok && wr)
            for (int k = 0; k < nb; k++) mb[a + k] = d[8*k +: 8];
        if (ok && rd) begin
            v = '0;
            for (int k = 0; k < nb; k++) v[8*k +: 8] = mb[a + k];
            if (!u && nb < 4 && v[8*nb-1])
                for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
            exp_rd = v;
        end
    endfunction

    task automatic wait_init(output int cnt);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            cnt++;
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_init();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b expected 0", rv); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        wait_init(cnt);
        checks++; if (cnt != 128) begin errors++; $display("FAIL init_length: got %0d expected 128", cnt); end
    endtask

    task automatic test_directed();
        logic [31:0] bexp [4];
        bexp[0] = 32'hFFFFFFEF; bexp[1] = 32'hFFFFFFBE; bexp[2] = 32'hFFFFFFAD; bexp[3] = 32'hFFFFFFDE;
        drive(1, 0, 32'h14, 0, 2'd2, 0); model_req(1, 0, 32'h14, 0, 2'd2, 0);
        checks++; if (rv !== 1'b1 || rdata !== 32'h5) begin errors++; $display("FAIL load_0x14: got rv=%b %h expected rv=1 00000005", rv, rdata); end
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (rv !== 1'b0 || rdata !== 32'h5) begin errors++; $display("FAIL rv_pulse_hold: got rv=%b %h expected rv=0 00000005", rv, rdata); end
        drive(0, 1, 32'h20, 32'hDEADBEEF, 2'd2, 0); model_req(0, 1, 32'h20, 32'hDEADBEEF, 2'd2, 0);
        checks++; if (err !== 1'b0 || rv !== 1'b0) begin errors++; $display("FAIL store_word: got err=%b rv=%b expected 0 0", err, rv); end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h20 + 32'(i), 0, 2'd0, 0); model_req(1, 0, 32'h20 + 32'(i), 0, 2'd0, 0);
            checks++; if (rv !== 1'b1 || rdata !== bexp[i]) begin errors++; $display("FAIL load_byte_s[%0d]: got %h expected %h", i, rdata, bexp[i]); end
        end
        drive(1, 0, 32'h23, 0, 2'd0, 1); model_req(1, 0, 32'h23, 0, 2'd0, 1);
        checks++; if (rdata !== 32'h000000DE) begin errors++; $display("FAIL load_byte_u: got %h expected 000000DE", rdata); end
        drive(0, 1, 32'h42, 32'h12348001, 2'd1, 0); model_req(0, 1, 32'h42, 32'h12348001, 2'd1, 0);
        drive(1, 0, 32'h40, 0, 2'd2, 0); model_req(1, 0, 32'h40, 0, 2'd2, 0);
        checks++; if (rdata !== 32'h80010010) begin errors++; $display("FAIL half_store_word: got %h expected 80010010", rdata); end
        drive(1, 0, 32'h42, 0, 2'd1, 0); model_req(1, 0, 32'h42, 0, 2'd1, 0);
        checks++; if (rdata !== 32'hFFFF8001) begin errors++; $display("FAIL load_half_s: got %h expected FFFF8001", rdata); end
    endtask

    task automatic test_errors();
        logic [31:0] ta [5];
        logic [1:0]  ts [5];
        bit          trd [5];
        bit          twr [5];
        logic [31:0] hold;
        ta[0] = 32'h02;  ts[0] = 2'd2; trd[0] = 1; twr[0] = 0;
        ta[1] = 32'h01;  ts[1] = 2'd1; trd[1] = 0; twr[1] = 1;
        ta[2] = 32'h00;  ts[2] = 2'd3; trd[2] = 1; twr[2] = 0;
        ta[3] = 32'h200; ts[3] = 2'd2; trd[3] = 1; twr[3] = 0;
        ta[4] = 32'h20;  ts[4] = 2'd2; trd[4] = 1; twr[4] = 1;
        hold = exp_rd;
        for (int i = 0; i < 5; i++) begin
            drive(trd[i], twr[i], ta[i], 32'h55AA55AA, ts[i], 0);
            model_req(trd[i], twr[i], ta[i], 32'h55AA55AA, ts[i], 0);
            checks++; if (err !== 1'b1 || rv !== 1'b0 || rdata !== hold) begin errors++; $display("FAIL reject[%0d]: got err=%b rv=%b %h expected err=1 rv=0 %h", i, err, rv, rdata, hold); end
            drive(0, 0, 0, 0, 0, 0);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse[%0d]: got %b expected 0", i, err); end
        end
        drive(1, 0, 32'h0, 0, 2'd2, 0); model_req(1, 0, 32'h0, 0, 2'd2, 0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unchanged_0x0: got %h expected 00000000", rdata); end
        drive(1, 0, 32'h20, 0, 2'd2, 0); model_req(1, 0, 32'h20, 0, 2'd2, 0);
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL unchanged_0x20: got %h expected DEADBEEF", rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d;
        logic [1:0]  s;
        for (int i = 0; i < 20; i++) begin
            s = 2'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 511)) & ~((32'd1 << s) - 32'd1);
            d = $urandom;
            drive(0, 1, a, d, s, 0); model_req(0, 1, a, d, s, 0);
            drive(1, 0, a & ~32'd3, 0, 2'd2, 0); model_req(1, 0, a & ~32'd3, 0, 2'd2, 0);
            checks++; if (rv !== 1'b1 || rdata !== exp_rd) begin errors++; $display("FAIL b2b[%0d] @%h: got rv=%b %h expected rv=1 %h", i, a, rv, rdata, exp_rd); end
        end
    endtask

    task automatic test_reset_mid_init();
        int cnt;
        drive(0, 1, 32'h3C, 32'hA5A5A5A5, 2'd2, 0);
        drive(0, 1, 32'h0, 32'h5A5A5A5A, 2'd2, 0);
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0); rst = 1'b0;
        for (int i = 0; i < 60; i++) drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0); rst = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midinit_busy: got %b expected 1", busy); end
        model_init();
        wait_init(cnt);
        checks++; if (cnt != 128) begin errors++; $display("FAIL midinit_length: got %0d expected 128", cnt); end
        drive(1, 0, 32'h3C, 0, 2'd2, 0); model_req(1, 0, 32'h3C, 0, 2'd2, 0);
        checks++; if (rdata !== 32'h0F) begin errors++; $display("FAIL midinit_0x3C: got %h expected 0000000F", rdata); end
        drive(1, 0, 32'h0, 0, 2'd2, 0); model_req(1, 0, 32'h0, 0, 2'd2, 0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL midinit_0x0: got %h expected 00000000", rdata); end
    endtask

    task automatic test_busy_ignore();
        int          cnt;
        bit          rd, wr;
        logic [31:0] a;
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0); rst = 1'b0;
        model_init();
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            a = (i % 2 == 0) ? 32'(4 * $urandom_range(0, 127)) : 32'($urandom_range(0, 1023));
            drive(rd, wr, a, $urandom, 2'($urandom_range(0, 3)), 0);
            cnt++;
            if (!busy) break;
            checks++; if (err !== 1'b0 || rv !== 1'b0) begin errors++; $display("FAIL busy_ignore[%0d]: got err=%b rv=%b expected 0 0", i, err, rv); end
        end
        checks++; if (cnt != 128) begin errors++; $display("FAIL busy_length: got %0d expected 128", cnt); end
        for (int w = 0; w < 128; w += 9) begin
            drive(1, 0, 32'(4 * w), 0, 2'd2, 0); model_req(1, 0, 32'(4 * w), 0, 2'd2, 0);
            checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL busy_nowrite[%0d]: got %h expected %h", w, rdata, exp_rd); end
        end
    endtask

    task automatic test_random();
        int          op;
        bit          rd, wr, u;
        logic [1:0]  s;
        logic [31:0] a, d;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            rd = (op <= 3) || (op == 8);
            wr = (op >= 4 && op <= 8);
            s  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << s) - 32'd1);
            if ($urandom_range(0, 19) == 0) a = a | 32'(1 << $urandom_range(9, 31));
            d  = $urandom;
            u  = 1'($urandom_range(0, 1));
            drive(rd, wr, a, d, s, u); model_req(rd, wr, a, d, s, u);
            checks++;
            if (rv !== exp_v || err !== exp_e || rdata !== exp_rd) begin
                errors++;
                $display("FAIL rand[%0d] rd=%b wr=%b a=%h s=%0d: got rv=%b err=%b %h expected rv=%b err=%b %h",
                         i, rd, wr, a, s, rv, err, rdata, exp_v, exp_e, exp_rd);
            end
        end
    endtask

    initial begin
        model_init();
        test_reset();
        test_directed();
        test_errors();
        test_back_to_back();
        test_reset_mid_init();
        test_busy_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
